ddr_port_arbiter: RTL
=====================

Name: ddr_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the DDR3 memory-interface application port: command, address, 256-bit write data and read-return.
- Port 0 is typically the video-input write path; port 1 is the video-output read path. Either port may issue reads or writes.
- Fair round-robin arbitration; exactly one single-beat transaction in flight at a time.
- Blocks all traffic until DDR calibration completes. Flags lost read returns with a sticky timeout.

Parameters:
ADDR_WIDTH, 29, DDR application address width
DATA_WIDTH, 256, application data width; mask width is DATA_WIDTH/8
RD_TIMEOUT, 1023, max clk cycles to wait for rd_data_valid after a read command (>=2)

Ports:
clk  in  1  application clock (DDR IP clk_out domain)
rst_n  in  1  asynchronous active-low reset
I_init_calib_complete  in  1  DDR calibration done; 0 holds arbiter idle
pN_req  in  1  port N (N=0,1) request; held until pN_ack
pN_cmd  in  1  port N command: 0 write, 1 read
pN_addr  in  ADDR_WIDTH  port N address
pN_wr_data  in  DATA_WIDTH  port N write beat
pN_wr_mask  in  DATA_WIDTH/8  port N byte mask, 1 = masked
pN_ack  out  1  one-cycle pulse: port N command accepted by DDR
pN_rd_valid  out  1  read data valid for port N
O_rd_data  out  DATA_WIDTH  shared read-return data, qualified by pN_rd_valid
I_cmd_ready  in  1  DDR accepts command
O_cmd  out  3  DDR command: 3'd0 write, 3'd1 read
O_cmd_en  out  1  DDR command strobe
O_addr  out  ADDR_WIDTH  DDR address
I_wr_data_rdy  in  1  DDR accepts write data
O_wr_data_en  out  1  write data strobe
O_wr_data_end  out  1  last write beat; always equal to O_wr_data_en
O_wr_data  out  DATA_WIDTH  write data
O_wr_data_mask  out  DATA_WIDTH/8  write mask
I_rd_data_valid  in  1  DDR read data valid
I_rd_data  in  DATA_WIDTH  DDR read data
O_busy  out  1  state != IDLE
O_rd_timeout  out  1  sticky read-timeout error flag

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, last_grant=1 (port 0 wins the first tie).
  - O_cmd, O_addr, O_wr_data, O_wr_data_mask, grant and timeout counter all 0.
  - Every output is 0.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
- IDLE:
  - If I_init_calib_complete=1 and any pN_req=1, select a port.
  - Only one port requesting: that port. Both requesting: the port != last_grant.
  - On selection, register grant, O_addr<=pN_addr, O_cmd<={2'b0,pN_cmd}, O_wr_data<=pN_wr_data, O_wr_data_mask<=pN_wr_mask, last_grant<=grant.
  - Next state is WR_ISSUE or RD_ISSUE. Request seen in cycle n gives the earliest DDR strobe in cycle n+1.
- WR_ISSUE:
  - O_cmd_en = O_wr_data_en = O_wr_data_end = I_cmd_ready & I_wr_data_rdy (combinational).
  - The same cycle pulses pN_ack for the granted port; next state IDLE.
  - Otherwise hold with all strobes at 0.
- RD_ISSUE:
  - O_cmd_en = I_cmd_ready; pN_ack pulses in the same cycle; next state RD_WAIT; counter cleared.
- RD_WAIT:
  - O_rd_data = I_rd_data, pN_rd_valid = I_rd_data_valid for the granted port only, combinational.
  - First I_rd_data_valid returns to IDLE.
  - Counter increments each cycle without valid. Counter reaching RD_TIMEOUT sets O_rd_timeout (cleared only by reset) and returns to IDLE without rd_valid.
- I_rd_data_valid outside RD_WAIT is ignored: no pN_rd_valid.
- One transaction at a time. Back-to-back requests from the same port with the other idle: one IDLE cycle between transactions, minimum 2-cycle spacing.
- I_init_calib_complete falling in any state:
  - Return to IDLE next cycle with no ack; strobes forced 0 immediately.
  - An unacked request is re-arbitrated after calibration returns.
- pN_req dropped before ack: the registered transaction still completes (requester contract violation, no protection).
- Never two acks in one cycle. Never a strobe with no grant.
- O_busy = (state != IDLE).

Test Plan:
- Calibration gating: I_init_calib_complete=0, p0_req=1 write for 20 cycles -> O_cmd_en stays 0. Raise calibration -> O_cmd_en=O_wr_data_en=O_wr_data_end=1 with O_cmd=0, O_addr=p0_addr, one p0_ack pulse.
- Round-robin: p0 and p1 both request writes continuously, I_cmd_ready=I_wr_data_rdy=1 -> acks alternate p0,p1,p0,p1. O_addr matches each granted port.
- Write backpressure: I_wr_data_rdy=0 for 5 cycles in WR_ISSUE -> no strobe and no ack. Then 1 -> a single strobe cycle carrying the held data/mask.
- Read routing: p1 read addr=0x100, I_rd_data_valid asserted 7 cycles after cmd_en with data 0xA5.. -> p1_rd_valid=1 for one cycle, p0_rd_valid=0, O_rd_data=0xA5..
- Read timeout: RD_TIMEOUT=8, no I_rd_data_valid -> O_rd_timeout=1 after 8 cycles in RD_WAIT, state IDLE, flag persists. Next request is served normally.
- Reset mid-read: rst_n=0 in RD_WAIT -> all outputs 0 asynchronously. After release, p0 wins a simultaneous p0/p1 request.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the DDR3 application port.
// One single-beat transaction in flight at a time; sticky flag for lost read returns.
module ddr_port_arbiter #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    I_init_calib_complete,
    input  logic                    p0_req,
    input  logic                    p0_cmd,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wr_data,
    input  logic [DATA_WIDTH/8-1:0] p0_wr_mask,
    output logic                    p0_ack,
    output logic                    p0_rd_valid,
    input  logic                    p1_req,
    input  logic                    p1_cmd,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wr_data,
    input  logic [DATA_WIDTH/8-1:0] p1_wr_mask,
    output logic                    p1_ack,
    output logic                    p1_rd_valid,
    output logic [DATA_WIDTH-1:0]   O_rd_data,
    input  logic                    I_cmd_ready,
    output logic [2:0]              O_cmd,
    output logic                    O_cmd_en,
    output logic [ADDR_WIDTH-1:0]   O_addr,
    input  logic                    I_wr_data_rdy,
    output logic                    O_wr_data_en,
    output logic                    O_wr_data_end,
    output logic [DATA_WIDTH-1:0]   O_wr_data,
    output logic [DATA_WIDTH/8-1:0] O_wr_data_mask,
    input  logic                    I_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]   I_rd_data,
    output logic                    O_busy,
    output logic                    O_rd_timeout
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

    state_t           state, state_nxt;
    logic             grant, last_grant;
    logic [CNT_W-1:0] to_cnt;
    logic             sel_port, sel_cmd;
    logic             load, issue_ack, rd_vld, cnt_clr, cnt_inc, to_set;

    // A lone requester always wins; on a tie the port not served last wins.
    assign sel_port = (p0_req && p1_req) ? ~last_grant : p1_req;
    assign sel_cmd  = sel_port ? p1_cmd : p0_cmd;

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        issue_ack    = 1'b0;
        rd_vld       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        to_set       = 1'b0;
        O_cmd_en     = 1'b0;
        O_wr_data_en = 1'b0;
        O_rd_data    = '0;
        case (state)
            IDLE: begin
                if (I_init_calib_complete && (p0_req || p1_req)) begin
                    load      = 1'b1;
                    state_nxt = sel_cmd ? RD_ISSUE : WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (!I_init_calib_complete) begin
                    state_nxt = IDLE;
                end else if (I_cmd_ready && I_wr_data_rdy) begin
                    O_cmd_en     = 1'b1;
                    O_wr_data_en = 1'b1;
                    issue_ack    = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!I_init_calib_complete) begin
                    state_nxt = IDLE;
                end else if (I_cmd_ready) begin
                    O_cmd_en  = 1'b1;
                    issue_ack = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                O_rd_data = I_rd_data;
                rd_vld    = I_rd_data_valid;
                if (!I_init_calib_complete || I_rd_data_valid) begin
                    state_nxt = IDLE;
                end else if (to_cnt == CNT_LAST) begin
                    to_set    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign O_wr_data_end = O_wr_data_en;
    assign p0_ack        = issue_ack & ~grant;
    assign p1_ack        = issue_ack & grant;
    assign p0_rd_valid   = rd_vld & ~grant;
    assign p1_rd_valid   = rd_vld & grant;
    assign O_busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            O_cmd          <= '0;
            O_addr         <= '0;
            O_wr_data      <= '0;
            O_wr_data_mask <= '0;
            to_cnt         <= '0;
            O_rd_timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                grant          <= sel_port;
                last_grant     <= sel_port;
                O_addr         <= sel_port ? p1_addr : p0_addr;
                O_cmd          <= {2'b00, sel_cmd};
                O_wr_data      <= sel_port ? p1_wr_data : p0_wr_data;
                O_wr_data_mask <= sel_port ? p1_wr_mask : p0_wr_mask;
            end
            if (cnt_clr) begin
                to_cnt <= '0;
            end else if (cnt_inc) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if (to_set) begin
                O_rd_timeout <= 1'b1;
            end
        end
    end

endmodule
